// File: rtl/instr_prefetch_queue_if.sv
// Bus bundle between the prefetch queue, instruction memory and the core's IR-load point.
interface instr_prefetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              ir_valid;
    logic [DATA_W-1:0] ir_data;
    logic [ADDR_W-1:0] ir_pc;
    logic              ir_ready;

    modport master (
        input  redirect_valid, redirect_pc, halt, mem_gnt, mem_rvalid, mem_rdata, ir_ready,
        output mem_req, mem_addr, ir_valid, ir_data, ir_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, halt, mem_gnt, mem_rvalid, mem_rdata, ir_ready,
        input  mem_req, mem_addr, ir_valid, ir_data, ir_pc
    );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Sequential instruction prefetcher: credit-limited memory reads into an in-order
// show-ahead queue, with redirect flush and stale-response dropping.
module instr_prefetch_queue #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input logic                    clk,
    input logic                    rst_n,
    instr_prefetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;

    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1'b1);
    localparam logic [PTR_W-1:0]  PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [SUM_W-1:0]  SUM_DEPTH = SUM_W'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1'b1);

    logic [ADDR_W-1:0] fetch_pc_r;
    logic [ADDR_W-1:0] resp_pc_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  inflight_r;
    logic [CNT_W-1:0]  drop_r;
    logic [DATA_W-1:0] q_data_r [DEPTH];
    logic [ADDR_W-1:0] q_pc_r   [DEPTH];

    logic [SUM_W-1:0]  occupancy_s;
    logic              mem_req_s;
    logic              grant_s;
    logic              resp_s;
    logic              drop_hit_s;
    logic              push_s;
    logic              pop_s;
    logic [CNT_W-1:0]  inflight_nxt_s;
    logic [CNT_W-1:0]  count_nxt_s;

    // Credit check, handshake qualification and next-count arithmetic.
    always_comb begin
        occupancy_s    = {1'b0, count_r} + {1'b0, inflight_r};
        mem_req_s      = rst_n & ~bus.halt & ~bus.redirect_valid & (occupancy_s < SUM_DEPTH);
        grant_s        = mem_req_s & bus.mem_gnt;
        // A response with nothing outstanding is a protocol error and is ignored.
        resp_s         = bus.mem_rvalid & (inflight_r != CNT_ZERO);
        drop_hit_s     = resp_s & (drop_r != CNT_ZERO);
        push_s         = resp_s & ~drop_hit_s & ~bus.redirect_valid;
        pop_s          = (count_r != CNT_ZERO) & bus.ir_ready & ~bus.redirect_valid;
        inflight_nxt_s = inflight_r + (grant_s ? CNT_ONE : CNT_ZERO)
                                    - (resp_s  ? CNT_ONE : CNT_ZERO);
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Fetch/response PCs, queue storage, pointers and in-flight accounting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_r <= RESET_PC;
            resp_pc_r  <= RESET_PC;
            rd_ptr_r   <= PTR_ZERO;
            wr_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            inflight_r <= CNT_ZERO;
            drop_r     <= CNT_ZERO;
            q_data_r   <= '{default: {DATA_W{1'b0}}};
            q_pc_r     <= '{default: {ADDR_W{1'b0}}};
        end else begin
            inflight_r <= inflight_nxt_s;
            if (bus.redirect_valid) begin
                // Everything still outstanding after this edge belongs to the old stream.
                fetch_pc_r <= bus.redirect_pc;
                resp_pc_r  <= bus.redirect_pc;
                rd_ptr_r   <= PTR_ZERO;
                wr_ptr_r   <= PTR_ZERO;
                count_r    <= CNT_ZERO;
                drop_r     <= inflight_nxt_s;
            end else begin
                if (grant_s) begin
                    fetch_pc_r <= fetch_pc_r + ADDR_ONE;
                end
                if (drop_hit_s) begin
                    drop_r <= drop_r - CNT_ONE;
                end
                if (push_s) begin
                    q_data_r[wr_ptr_r] <= bus.mem_rdata;
                    q_pc_r[wr_ptr_r]   <= resp_pc_r;
                    wr_ptr_r           <= wr_ptr_r + PTR_ONE;
                    resp_pc_r          <= resp_pc_r + ADDR_ONE;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE;
                end
                count_r <= count_nxt_s;
            end
        end
    end

    assign bus.mem_req  = mem_req_s;
    assign bus.mem_addr = fetch_pc_r;
    assign bus.ir_valid = (count_r != CNT_ZERO);
    assign bus.ir_data  = q_data_r[rd_ptr_r];
    assign bus.ir_pc    = q_pc_r[rd_ptr_r];
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with an in-order latency-programmable memory model.
module tb_instr_prefetch_queue;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   tcnt = 0;
    int   lat = 1;
    int   grant_cnt = 0;
    int   g0;
    int   n;
    logic [31:0] pend_addr [$];
    int          pend_due  [$];

    instr_prefetch_queue_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    instr_prefetch_queue #(
        .DEPTH(4), .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tcnt++;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory model: grant seen at edge tcnt+1 returns data at edge tcnt+1+lat.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend_addr.delete();
            pend_due.delete();
            bus_if.mem_rvalid = 1'b0;
            bus_if.mem_rdata  = 32'h0;
        end else begin
            if (pend_due.size() > 0 && pend_due[0] == tcnt + 1) begin
                bus_if.mem_rvalid = 1'b1;
                bus_if.mem_rdata  = mem_word(pend_addr[0]);
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                bus_if.mem_rvalid = 1'b0;
                bus_if.mem_rdata  = 32'h0;
            end
            if (bus_if.mem_req && bus_if.mem_gnt) begin
                pend_addr.push_back(bus_if.mem_addr);
                pend_due.push_back(tcnt + 1 + lat);
                grant_cnt++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic reset_dut;
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        settle;
    endtask

    initial begin
        bus_if.halt           = 1'b0;
        bus_if.redirect_valid = 1'b0;
        bus_if.redirect_pc    = 32'h0;
        bus_if.mem_gnt        = 1'b1;
        bus_if.ir_ready       = 1'b1;
        tick; tick; tick;
        chk("rst_mem_req",  {63'h0, bus_if.mem_req}, 64'h0);
        chk("rst_mem_addr", {32'h0, bus_if.mem_addr}, 64'h0);
        chk("rst_ir_valid", {63'h0, bus_if.ir_valid}, 64'h0);
        chk("rst_ir_data",  {32'h0, bus_if.ir_data}, 64'h0);
        chk("rst_ir_pc",    {32'h0, bus_if.ir_pc}, 64'h0);

        // Streaming with latency 1
        rst_n = 1'b1;
        settle;
        chk("stream_req0",  {63'h0, bus_if.mem_req}, 64'h1);
        chk("stream_addr0", {32'h0, bus_if.mem_addr}, 64'h0);
        tick;
        chk("stream_addr1", {32'h0, bus_if.mem_addr}, 64'h1);
        chk("stream_nv1",   {63'h0, bus_if.ir_valid}, 64'h0);
        tick;
        for (int i = 0; i < 3; i++) begin
            chk("stream_valid", {63'h0, bus_if.ir_valid}, 64'h1);
            chk("stream_pc",    {32'h0, bus_if.ir_pc}, 64'(i));
            chk("stream_data",  {32'h0, bus_if.ir_data}, {32'h0, mem_word(32'(i))});
            chk("stream_addr",  {32'h0, bus_if.mem_addr}, 64'(i + 2));
            tick;
        end

        // Stall: core not ready, queue fills to 4
        bus_if.ir_ready = 1'b0;
        reset_dut;
        g0 = grant_cnt;
        repeat (10) tick;
        chk("stall_grants", 64'(grant_cnt - g0), 64'h4);
        chk("stall_req",    {63'h0, bus_if.mem_req}, 64'h0);
        chk("stall_valid",  {63'h0, bus_if.ir_valid}, 64'h1);
        chk("stall_pc0",    {32'h0, bus_if.ir_pc}, 64'h0);
        chk("stall_data0",  {32'h0, bus_if.ir_data}, {32'h0, mem_word(32'h0)});
        bus_if.ir_ready = 1'b1;
        tick;
        chk("resume_req",  {63'h0, bus_if.mem_req}, 64'h1);
        chk("resume_addr", {32'h0, bus_if.mem_addr}, 64'h4);
        for (int i = 1; i < 5; i++) begin
            chk("drain_pc",   {32'h0, bus_if.ir_pc}, 64'(i));
            chk("drain_data", {32'h0, bus_if.ir_data}, {32'h0, mem_word(32'(i))});
            tick;
        end

        // Redirect with two responses in flight, latency 3
        lat = 3;
        reset_dut;
        tick; tick;
        chk("lat3_addr2", {32'h0, bus_if.mem_addr}, 64'h2);
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'd40;
        settle;
        chk("redir_req_blocked", {63'h0, bus_if.mem_req}, 64'h0);
        tick;
        bus_if.redirect_valid = 1'b0;
        settle;
        chk("redir_nv",   {63'h0, bus_if.ir_valid}, 64'h0);
        chk("redir_req",  {63'h0, bus_if.mem_req}, 64'h1);
        chk("redir_addr", {32'h0, bus_if.mem_addr}, 64'd40);
        n = 0;
        while (!bus_if.ir_valid && n < 20) begin
            tick;
            n++;
        end
        chk("redir_wait", 64'(n), 64'h4);
        chk("redir_pc",   {32'h0, bus_if.ir_pc}, 64'd40);
        chk("redir_data", {32'h0, bus_if.ir_data}, {32'h0, mem_word(32'd40)});

        // Redirect coinciding with head handshake and an accepted response
        lat = 1;
        reset_dut;
        tick; tick;
        chk("coin_head_valid", {63'h0, bus_if.ir_valid}, 64'h1);
        chk("coin_head_pc",    {32'h0, bus_if.ir_pc}, 64'h0);
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'd100;
        settle;
        chk("coin_req_blocked", {63'h0, bus_if.mem_req}, 64'h0);
        tick;
        bus_if.redirect_valid = 1'b0;
        settle;
        chk("coin_empty", {63'h0, bus_if.ir_valid}, 64'h0);
        chk("coin_req",   {63'h0, bus_if.mem_req}, 64'h1);
        chk("coin_addr",  {32'h0, bus_if.mem_addr}, 64'd100);
        tick;
        chk("coin_empty2", {63'h0, bus_if.ir_valid}, 64'h0);
        tick;
        chk("coin_valid", {63'h0, bus_if.ir_valid}, 64'h1);
        chk("coin_pc",    {32'h0, bus_if.ir_pc}, 64'd100);
        chk("coin_data",  {32'h0, bus_if.ir_data}, {32'h0, mem_word(32'd100)});

        // Halt with one request in flight, redirect during halt
        reset_dut;
        tick;
        bus_if.halt = 1'b1;
        settle;
        chk("halt_req", {63'h0, bus_if.mem_req}, 64'h0);
        g0 = grant_cnt;
        tick;
        chk("halt_enq_valid", {63'h0, bus_if.ir_valid}, 64'h1);
        chk("halt_enq_pc",    {32'h0, bus_if.ir_pc}, 64'h0);
        chk("halt_enq_data",  {32'h0, bus_if.ir_data}, {32'h0, mem_word(32'h0)});
        tick;
        chk("halt_drained", {63'h0, bus_if.ir_valid}, 64'h0);
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'd16;
        tick;
        bus_if.redirect_valid = 1'b0;
        repeat (3) tick;
        chk("halt_req_held", {63'h0, bus_if.mem_req}, 64'h0);
        chk("halt_no_grant", 64'(grant_cnt - g0), 64'h0);
        bus_if.halt = 1'b0;
        settle;
        chk("unhalt_req",  {63'h0, bus_if.mem_req}, 64'h1);
        chk("unhalt_addr", {32'h0, bus_if.mem_addr}, 64'd16);

        // Address wrap at the top of the address space
        reset_dut;
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'hFFFF_FFFE;
        tick;
        bus_if.redirect_valid = 1'b0;
        settle;
        chk("wrap_req",   {63'h0, bus_if.mem_req}, 64'h1);
        chk("wrap_addr0", {32'h0, bus_if.mem_addr}, 64'hFFFF_FFFE);
        tick;
        chk("wrap_addr1", {32'h0, bus_if.mem_addr}, 64'hFFFF_FFFF);
        tick;
        chk("wrap_addr2", {32'h0, bus_if.mem_addr}, 64'h0);
        chk("wrap_pc0",   {32'h0, bus_if.ir_pc}, 64'hFFFF_FFFE);
        tick;
        chk("wrap_pc1",   {32'h0, bus_if.ir_pc}, 64'hFFFF_FFFF);
        tick;
        chk("wrap_pc2",   {32'h0, bus_if.ir_pc}, 64'h0);
        chk("wrap_data2", {32'h0, bus_if.ir_data}, {32'h0, mem_word(32'h0)});

        // Mid-stream reset
        chk("mid_valid_pre", {63'h0, bus_if.ir_valid}, 64'h1);
        rst_n = 1'b0;
        tick;
        chk("mid_rst_req",   {63'h0, bus_if.mem_req}, 64'h0);
        chk("mid_rst_addr",  {32'h0, bus_if.mem_addr}, 64'h0);
        chk("mid_rst_valid", {63'h0, bus_if.ir_valid}, 64'h0);
        chk("mid_rst_data",  {32'h0, bus_if.ir_data}, 64'h0);
        chk("mid_rst_pc",    {32'h0, bus_if.ir_pc}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
